// File: rtl/variance_norm_scheduler.sv
// variance_norm_scheduler
// Hands the two variance-cache banks (A/B) to the window-fill producer in turn,
// launches the normalisation calculator on each filled bank in order, and returns
// the factor with its window tag on a valid/ready output before freeing the bank.
//
// Handshakes:
//   res_valid/res_ready : a result moves when res_valid && res_ready are both high
//                         on a rising clk edge. Once raised, res_valid and its
//                         payload stay unchanged until that transfer happens.
//   calc_start/calc_taken: one-cycle pulses. calc_valid is expected to stay high
//                         until the scheduler has captured the result; calc_taken
//                         then confirms the capture back to the calculator.
//   fill_gnt/fill_done : fill_gnt is a one-cycle pulse naming fill_bank; the
//                         producer answers with fill_done (plus fill_tag) once the
//                         bank is written.
// dbg_state exposes the calculator FSM state for observation.
module variance_norm_scheduler #(
  parameter int FIXEDBITS = 32,
  parameter int TAGW      = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fill_req,
  output logic                 fill_gnt,
  output logic                 fill_bank,
  input  logic                 fill_done,
  input  logic [TAGW-1:0]      fill_tag,
  input  logic                 calc_ready,
  output logic                 calc_start,
  output logic                 calc_dblbuf,
  input  logic                 calc_valid,
  input  logic [FIXEDBITS-1:0] calc_result,
  output logic                 calc_taken,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FIXEDBITS-1:0] res_factor,
  output logic [TAGW-1:0]      res_tag,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN} state_t;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_CALC} bank_t;

  state_t                 r_state, w_state;
  bank_t                  r_bank [2];
  bank_t                  w_bank [2];
  logic [TAGW-1:0]        r_tag [2];
  logic [TAGW-1:0]        w_tag [2];
  logic                   r_fill_ptr, w_fill_ptr;
  logic                   r_calc_ptr, w_calc_ptr;
  logic                   r_fill_gnt, w_fill_gnt;
  logic                   r_fill_bank, w_fill_bank;
  logic                   r_calc_start, w_calc_start;
  logic                   r_calc_dblbuf, w_calc_dblbuf;
  logic                   r_calc_taken, w_calc_taken;
  logic                   r_res_valid, w_res_valid;
  logic [FIXEDBITS-1:0]   r_res_factor, w_res_factor;
  logic [TAGW-1:0]        r_res_tag, w_res_tag;
  logic                   r_busy, w_busy;
  logic                   r_timeout_err, w_timeout_err;
  logic [CW-1:0]          r_to_cnt, w_to_cnt;
  logic                   w_any_filling;
  logic                   w_slot_free;

  // Calculator FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state;
  end

  // Next state for the FSM, bank bookkeeping and every registered output
  always_comb begin
    w_state       = r_state;
    w_bank        = r_bank;
    w_tag         = r_tag;
    w_fill_ptr    = r_fill_ptr;
    w_calc_ptr    = r_calc_ptr;
    w_fill_gnt    = 1'b0;
    w_fill_bank   = r_fill_bank;
    w_calc_start  = 1'b0;
    w_calc_dblbuf = r_calc_dblbuf;
    w_calc_taken  = 1'b0;
    w_res_valid   = r_res_valid;
    w_res_factor  = r_res_factor;
    w_res_tag     = r_res_tag;
    w_to_cnt      = r_to_cnt;
    w_timeout_err = r_timeout_err;
    w_any_filling = (r_bank[0] == B_FILLING) || (r_bank[1] == B_FILLING);
    w_slot_free   = !r_res_valid || res_ready;

    // Fill side: the FILLING bank is always the one under fill_ptr, since the
    // pointer only moves when that fill completes. Grant and done are exclusive.
    if (fill_req && (r_bank[r_fill_ptr] == B_FREE) && !w_any_filling) begin
      w_fill_gnt         = 1'b1;
      w_fill_bank        = r_fill_ptr;
      w_bank[r_fill_ptr] = B_FILLING;
    end else if (fill_done && w_any_filling) begin
      w_bank[r_fill_ptr] = B_FULL;
      w_tag[r_fill_ptr]  = fill_tag;
      w_fill_ptr         = ~r_fill_ptr;
    end

    // Downstream transfer empties the slot; a capture below may refill it
    if (r_res_valid && res_ready) w_res_valid = 1'b0;

    // Calc side only touches FULL/CALC banks, so it never collides with fill side
    case (r_state)
      S_IDLE: begin
        if ((r_bank[r_calc_ptr] == B_FULL) && calc_ready) begin
          w_state       = S_LAUNCH;
          w_calc_start  = 1'b1;
          w_calc_dblbuf = r_calc_ptr;
        end
      end
      S_LAUNCH: begin
        w_bank[r_calc_ptr] = B_CALC;
        w_to_cnt           = '0;
        w_state            = S_WAIT;
      end
      S_WAIT: begin
        if (calc_valid) begin
          // A blocked result freezes the timeout counter
          if (w_slot_free) begin
            w_state      = S_DRAIN;
            w_res_valid  = 1'b1;
            w_res_factor = calc_result;
            w_res_tag    = r_tag[r_calc_ptr];
          end
        end else if (r_to_cnt != CW'(TIMEOUT)) begin
          w_to_cnt = r_to_cnt + 1'b1;
          if (r_to_cnt == CW'(TIMEOUT - 1)) w_timeout_err = 1'b1;
        end
      end
      S_DRAIN: begin
        w_calc_taken       = 1'b1;
        w_bank[r_calc_ptr] = B_FREE;
        w_calc_ptr         = ~r_calc_ptr;
        w_state            = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_bank[0] != B_FREE) || (w_bank[1] != B_FREE) || w_res_valid;
  end

  // Bank bookkeeping, pointers, timeout counter and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bank[0]     <= B_FREE;
      r_bank[1]     <= B_FREE;
      r_tag[0]      <= '0;
      r_tag[1]      <= '0;
      r_fill_ptr    <= 1'b0;
      r_calc_ptr    <= 1'b0;
      r_fill_gnt    <= 1'b0;
      r_fill_bank   <= 1'b0;
      r_calc_start  <= 1'b0;
      r_calc_dblbuf <= 1'b0;
      r_calc_taken  <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_factor  <= '0;
      r_res_tag     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_bank        <= w_bank;
      r_tag         <= w_tag;
      r_fill_ptr    <= w_fill_ptr;
      r_calc_ptr    <= w_calc_ptr;
      r_fill_gnt    <= w_fill_gnt;
      r_fill_bank   <= w_fill_bank;
      r_calc_start  <= w_calc_start;
      r_calc_dblbuf <= w_calc_dblbuf;
      r_calc_taken  <= w_calc_taken;
      r_res_valid   <= w_res_valid;
      r_res_factor  <= w_res_factor;
      r_res_tag     <= w_res_tag;
      r_busy        <= w_busy;
      r_timeout_err <= w_timeout_err;
      r_to_cnt      <= w_to_cnt;
    end
  end

  assign fill_gnt    = r_fill_gnt;
  assign fill_bank   = r_fill_bank;
  assign calc_start  = r_calc_start;
  assign calc_dblbuf = r_calc_dblbuf;
  assign calc_taken  = r_calc_taken;
  assign res_valid   = r_res_valid;
  assign res_factor  = r_res_factor;
  assign res_tag     = r_res_tag;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_variance_norm_scheduler.sv
// Directed bench for variance_norm_scheduler. Inputs change on the falling edge,
// outputs are checked on the falling edge; every expectation is hand-derived.
module tb_variance_norm_scheduler;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic        clk;
  logic        resetn;
  logic        fill_req;
  logic        fill_gnt;
  logic        fill_bank;
  logic        fill_done;
  logic [15:0] fill_tag;
  logic        calc_ready;
  logic        calc_start;
  logic        calc_dblbuf;
  logic        calc_valid;
  logic [31:0] calc_result;
  logic        calc_taken;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_factor;
  logic [15:0] res_tag;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  variance_norm_scheduler #(.FIXEDBITS(32), .TAGW(16), .TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn),
    .fill_req(fill_req), .fill_gnt(fill_gnt), .fill_bank(fill_bank),
    .fill_done(fill_done), .fill_tag(fill_tag),
    .calc_ready(calc_ready), .calc_start(calc_start), .calc_dblbuf(calc_dblbuf),
    .calc_valid(calc_valid), .calc_result(calc_result), .calc_taken(calc_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_factor(res_factor),
    .res_tag(res_tag), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    resetn      = 1'b0;
    fill_req    = 1'b0;
    fill_done   = 1'b0;
    fill_tag    = 16'h0;
    calc_ready  = 1'b1;
    calc_valid  = 1'b0;
    calc_result = 32'h0;
    res_ready   = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [57:0] all_outs();
    return {fill_gnt, fill_bank, calc_start, calc_dblbuf, calc_taken, res_valid,
            res_factor, res_tag, busy, timeout_err, dbg_state};
  endfunction

  task automatic test_reset();
    logic [57:0] v;
    apply_reset();
    v = all_outs();
    total++; if (v !== 58'h0) begin bad++; $display("FAIL reset_outs got=%h exp=0", v); end
  endtask

  task automatic test_single_window();
    apply_reset();
    fill_req = 1'b1;
    @(negedge clk);
    total++; if (fill_gnt !== 1'b1) begin bad++; $display("FAIL single_gnt got=%b exp=1", fill_gnt); end
    total++; if (fill_bank !== 1'b0) begin bad++; $display("FAIL single_bank got=%b exp=0", fill_bank); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    fill_req = 1'b0; fill_done = 1'b1; fill_tag = 16'h0005;
    @(negedge clk);
    total++; if (fill_gnt !== 1'b0) begin bad++; $display("FAIL single_gnt_pulse got=%b exp=0", fill_gnt); end
    total++; if (calc_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%b exp=0", calc_start); end
    fill_done = 1'b0;
    @(negedge clk);
    total++; if (calc_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", calc_start); end
    total++; if (calc_dblbuf !== 1'b0) begin bad++; $display("FAIL single_dblbuf got=%b exp=0", calc_dblbuf); end
    @(negedge clk);
    total++; if (calc_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse got=%b exp=0", calc_start); end
    total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL single_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
    repeat (58) @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_no_timeout got=%b exp=0", timeout_err); end
    calc_valid = 1'b1; calc_result = 32'h0001_0000;
    @(negedge clk);
    calc_valid = 1'b0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_res_valid got=%b exp=1", res_valid); end
    total++; if (res_factor !== 32'h0001_0000) begin bad++; $display("FAIL single_factor got=%h exp=00010000", res_factor); end
    total++; if (res_tag !== 16'h0005) begin bad++; $display("FAIL single_tag got=%h exp=0005", res_tag); end
    total++; if (calc_taken !== 1'b0) begin bad++; $display("FAIL single_taken_early got=%b exp=0", calc_taken); end
    total++; if (dbg_state !== ST_DRAIN) begin bad++; $display("FAIL single_drain got=%0d exp=%0d", dbg_state, ST_DRAIN); end
    @(negedge clk);
    total++; if (calc_taken !== 1'b1) begin bad++; $display("FAIL single_taken got=%b exp=1", calc_taken); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_res_hold got=%b exp=1", res_valid); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL single_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++; if (calc_taken !== 1'b0) begin bad++; $display("FAIL single_taken_pulse got=%b exp=0", calc_taken); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_res_clear got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ping_pong_backpressure();
    apply_reset();
    fill_req = 1'b1;
    @(negedge clk);
    total++; if ({fill_gnt, fill_bank} !== 2'b10) begin bad++; $display("FAIL pp_gnt_a got=%b exp=10", {fill_gnt, fill_bank}); end
    fill_done = 1'b1; fill_tag = 16'h0001;
    @(negedge clk);
    total++; if (fill_gnt !== 1'b0) begin bad++; $display("FAIL pp_no_gnt_while_filling got=%b exp=0", fill_gnt); end
    fill_done = 1'b0;
    @(negedge clk);
    // grant of B coincides with launch of A
    total++; if ({fill_gnt, fill_bank} !== 2'b11) begin bad++; $display("FAIL pp_gnt_b got=%b exp=11", {fill_gnt, fill_bank}); end
    total++; if ({calc_start, calc_dblbuf} !== 2'b10) begin bad++; $display("FAIL pp_launch_a got=%b exp=10", {calc_start, calc_dblbuf}); end
    fill_req = 1'b0; fill_done = 1'b1; fill_tag = 16'h0002;
    @(negedge clk);
    fill_done = 1'b0;
    calc_valid = 1'b1; calc_result = 32'h1111_1111;
    @(negedge clk);
    calc_valid = 1'b0;
    total++; if ({res_valid, res_tag} !== 17'h1_0001) begin bad++; $display("FAIL pp_res1 got=%h exp=10001", {res_valid, res_tag}); end
    total++; if (calc_dblbuf !== 1'b0) begin bad++; $display("FAIL pp_dblbuf_stable got=%b exp=0", calc_dblbuf); end
    @(negedge clk);
    total++; if (calc_taken !== 1'b1) begin bad++; $display("FAIL pp_taken1 got=%b exp=1", calc_taken); end
    @(negedge clk);
    total++; if ({calc_start, calc_dblbuf} !== 2'b11) begin bad++; $display("FAIL pp_launch_b got=%b exp=11", {calc_start, calc_dblbuf}); end
    @(negedge clk);
    // result for B arrives while tag 1 is still unaccepted
    calc_valid = 1'b1; calc_result = 32'h2222_2222;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      total++; if (calc_taken !== 1'b0) begin bad++; $display("FAIL bp_no_taken cyc=%0d got=%b exp=0", i, calc_taken); end
    end
    total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL bp_stay_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
    total++; if (res_tag !== 16'h0001) begin bad++; $display("FAIL bp_tag_hold got=%h exp=0001", res_tag); end
    total++; if (res_factor !== 32'h1111_1111) begin bad++; $display("FAIL bp_factor_hold got=%h exp=11111111", res_factor); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL bp_counter_frozen got=%b exp=0", timeout_err); end
    res_ready = 1'b1;
    @(negedge clk);
    calc_valid = 1'b0; res_ready = 1'b0;
    total++; if ({res_valid, res_tag} !== 17'h1_0002) begin bad++; $display("FAIL bp_res2 got=%h exp=10002", {res_valid, res_tag}); end
    total++; if (res_factor !== 32'h2222_2222) begin bad++; $display("FAIL bp_factor2 got=%h exp=22222222", res_factor); end
    total++; if (dbg_state !== ST_DRAIN) begin bad++; $display("FAIL bp_drain got=%0d exp=%0d", dbg_state, ST_DRAIN); end
    @(negedge clk);
    total++; if ({calc_taken, res_valid} !== 2'b11) begin bad++; $display("FAIL bp_taken2 got=%b exp=11", {calc_taken, res_valid}); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL pp_final_idle got=%b exp=00", {res_valid, busy}); end
  endtask

  task automatic test_both_full();
    apply_reset();
    fill_req = 1'b1;
    @(negedge clk);
    fill_done = 1'b1; fill_tag = 16'h0003;
    @(negedge clk);
    fill_done = 1'b0;
    @(negedge clk);
    total++; if ({fill_gnt, fill_bank, calc_start} !== 3'b111) begin bad++; $display("FAIL bf_gnt_b_launch_a got=%b exp=111", {fill_gnt, fill_bank, calc_start}); end
    fill_done = 1'b1; fill_tag = 16'h0004;
    @(negedge clk);
    fill_done = 1'b0;
    total++; if (fill_gnt !== 1'b0) begin bad++; $display("FAIL bf_no_gnt0 got=%b exp=0", fill_gnt); end
    @(negedge clk);
    // no bank is filling: this done must be ignored
    fill_done = 1'b1; fill_tag = 16'hBEEF;
    @(negedge clk);
    fill_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (fill_gnt !== 1'b0) begin bad++; $display("FAIL bf_no_gnt cyc=%0d got=%b exp=0", i, fill_gnt); end
    end
    calc_valid = 1'b1; calc_result = 32'h3333_3333; res_ready = 1'b1;
    @(negedge clk);
    calc_valid = 1'b0;
    total++; if ({res_valid, res_tag} !== 17'h1_0003) begin bad++; $display("FAIL bf_res_a got=%h exp=10003", {res_valid, res_tag}); end
    total++; if (fill_gnt !== 1'b0) begin bad++; $display("FAIL bf_no_gnt_drain got=%b exp=0", fill_gnt); end
    @(negedge clk);
    total++; if ({calc_taken, fill_gnt} !== 2'b10) begin bad++; $display("FAIL bf_taken_a got=%b exp=10", {calc_taken, fill_gnt}); end
    @(negedge clk);
    // freed bank A granted while bank B launches
    total++; if ({fill_gnt, fill_bank} !== 2'b10) begin bad++; $display("FAIL bf_regrant_a got=%b exp=10", {fill_gnt, fill_bank}); end
    total++; if ({calc_start, calc_dblbuf} !== 2'b11) begin bad++; $display("FAIL bf_launch_b got=%b exp=11", {calc_start, calc_dblbuf}); end
    fill_req = 1'b0;
    @(negedge clk);
    calc_valid = 1'b1; calc_result = 32'h4444_4444;
    @(negedge clk);
    calc_valid = 1'b0; res_ready = 1'b0;
    total++; if ({res_valid, res_tag} !== 17'h1_0004) begin bad++; $display("FAIL bf_res_b got=%h exp=10004", {res_valid, res_tag}); end
    total++; if (res_factor !== 32'h4444_4444) begin bad++; $display("FAIL bf_factor_b got=%h exp=44444444", res_factor); end
  endtask

  task automatic test_timeout();
    apply_reset();
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0; fill_done = 1'b1; fill_tag = 16'h0007;
    @(negedge clk);
    fill_done = 1'b0;
    @(negedge clk);
    total++; if (calc_start !== 1'b1) begin bad++; $display("FAIL to_launch got=%b exp=1", calc_start); end
    repeat (255) @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_before_limit got=%b exp=0", timeout_err); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_at_limit got=%b exp=1", timeout_err); end
    repeat (10) @(negedge clk);
    total++; if ({timeout_err, dbg_state} !== {1'b1, ST_WAIT}) begin bad++; $display("FAIL to_sticky_wait got=%b exp=110", {timeout_err, dbg_state}); end
    calc_valid = 1'b1; calc_result = 32'h00AB_CDEF; res_ready = 1'b1;
    @(negedge clk);
    calc_valid = 1'b0;
    total++; if ({res_valid, res_tag} !== 17'h1_0007) begin bad++; $display("FAIL to_late_res got=%h exp=10007", {res_valid, res_tag}); end
    total++; if (res_factor !== 32'h00AB_CDEF) begin bad++; $display("FAIL to_late_factor got=%h exp=00abcdef", res_factor); end
    @(negedge clk);
    total++; if (calc_taken !== 1'b1) begin bad++; $display("FAIL to_taken got=%b exp=1", calc_taken); end
    @(negedge clk);
    res_ready = 1'b0;
    total++; if ({busy, timeout_err} !== 2'b01) begin bad++; $display("FAIL to_done got=%b exp=01", {busy, timeout_err}); end
  endtask

  // Continues from the timeout scenario: pointers sit on B and the error is set
  task automatic test_reset_mid();
    logic [57:0] v;
    fill_req = 1'b1;
    @(negedge clk);
    total++; if ({fill_gnt, fill_bank} !== 2'b11) begin bad++; $display("FAIL rm_gnt_b got=%b exp=11", {fill_gnt, fill_bank}); end
    fill_req = 1'b0; fill_done = 1'b1; fill_tag = 16'h0009;
    @(negedge clk);
    fill_done = 1'b0;
    @(negedge clk);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    total++; if ({fill_gnt, fill_bank, dbg_state, busy, timeout_err} !== {2'b10, ST_WAIT, 2'b11})
      begin bad++; $display("FAIL rm_pre_reset got=%b exp=101011", {fill_gnt, fill_bank, dbg_state, busy, timeout_err}); end
    resetn = 1'b0;
    @(negedge clk);
    v = all_outs();
    total++; if (v !== 58'h0) begin bad++; $display("FAIL rm_outs_cleared got=%h exp=0", v); end
    resetn = 1'b1; fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    total++; if ({fill_gnt, fill_bank, busy} !== 3'b101) begin bad++; $display("FAIL rm_regrant_a got=%b exp=101", {fill_gnt, fill_bank, busy}); end
  endtask

  initial begin
    resetn = 1'b0; fill_req = 1'b0; fill_done = 1'b0; fill_tag = 16'h0;
    calc_ready = 1'b1; calc_valid = 1'b0; calc_result = 32'h0; res_ready = 1'b0;
    test_reset();
    test_single_window();
    test_ping_pong_backpressure();
    test_both_full();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
